// File: rtl/y86_fde_core.sv
// Y86-64 fetch/decode/execute front end: combinational datapath from PC/imem_bytes to valE,
// with the register file and condition codes updated on posedge clk. Define REG_DEBUG_EN to expose reg_mem0..reg_mem14.
module y86_fde_core #(
   parameter int XLEN  = 64,
   parameter int NREGS = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  PC,
   input  logic [79:0]      imem_bytes,
   input  logic             imem_error,
   input  logic [XLEN-1:0]  valM,
   output logic [3:0]       icode,
   output logic [3:0]       ifun,
   output logic [3:0]       rA,
   output logic [3:0]       rB,
   output logic [XLEN-1:0]  valC,
   output logic [XLEN-1:0]  valP,
   output logic [XLEN-1:0]  valA,
   output logic [XLEN-1:0]  valB,
   output logic [XLEN-1:0]  valE,
   output logic             cnd,
   output logic             ZF,
   output logic             SF,
   output logic             OF,
   output logic             hlt,
   output logic             inst_valid
`ifdef REG_DEBUG_EN
   ,
   output logic [XLEN-1:0]  reg_mem0,  reg_mem1,  reg_mem2,  reg_mem3,  reg_mem4,
   output logic [XLEN-1:0]  reg_mem5,  reg_mem6,  reg_mem7,  reg_mem8,  reg_mem9,
   output logic [XLEN-1:0]  reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
`endif
);

   localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
   localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
   localparam logic [3:0] R_RSP = 4'h4, R_NONE = 4'hF;
   localparam logic [XLEN-1:0] STEP = XLEN'(8);

   logic [XLEN-1:0] regs [NREGS];
   logic [3:0]      ilen, src_a, src_b, dst_e, dst_m;
   logic            legal, wb_en, of_next;
   logic [XLEN-1:0] alu_a, alu_b;
   logic [1:0]      alu_fun;

   assign icode = imem_bytes[7:4];
   assign ifun  = imem_bytes[3:0];

   always_comb begin
      ilen  = 4'd1;
      legal = 1'b0;
      case (icode)
         I_HALT, I_NOP, I_RET:              begin ilen = 4'd1;  legal = (ifun == 4'h0); end
         I_RRMOVQ:                          begin ilen = 4'd2;  legal = (ifun <= 4'h6); end
         I_OPQ:                             begin ilen = 4'd2;  legal = (ifun <= 4'h3); end
         I_PUSHQ, I_POPQ:                   begin ilen = 4'd2;  legal = (ifun == 4'h0); end
         I_JXX:                             begin ilen = 4'd9;  legal = (ifun <= 4'h6); end
         I_CALL:                            begin ilen = 4'd9;  legal = (ifun == 4'h0); end
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:      begin ilen = 4'd10; legal = (ifun == 4'h0); end
         default:                           begin ilen = 4'd1;  legal = 1'b0; end
      endcase
   end

   assign inst_valid = legal & ~imem_error;
   assign hlt        = (icode == I_HALT) & inst_valid;
   assign valP       = inst_valid ? PC + XLEN'(ilen) : PC + XLEN'(1);
   assign rA         = (legal && (ilen == 4'd2 || ilen == 4'd10)) ? imem_bytes[15:12] : R_NONE;
   assign rB         = (legal && (ilen == 4'd2 || ilen == 4'd10)) ? imem_bytes[11:8]  : R_NONE;
   assign valC       = (legal && ilen == 4'd10) ? imem_bytes[79:16] :
                       (legal && ilen == 4'd9)  ? imem_bytes[71:8]  : '0;

   // Register-id selection; 0xF means "no register".
   always_comb begin
      src_a = R_NONE;
      src_b = R_NONE;
      dst_e = R_NONE;
      dst_m = R_NONE;
      case (icode)
         I_RRMOVQ: begin src_a = rA; dst_e = cnd ? rB : R_NONE; end
         I_IRMOVQ: dst_e = rB;
         I_RMMOVQ: begin src_a = rA; src_b = rB; end
         I_MRMOVQ: begin src_b = rB; dst_m = rA; end
         I_OPQ:    begin src_a = rA; src_b = rB; dst_e = rB; end
         I_CALL:   begin src_b = R_RSP; dst_e = R_RSP; end
         I_RET:    begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; end
         I_PUSHQ:  begin src_a = rA; src_b = R_RSP; dst_e = R_RSP; end
         I_POPQ:   begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; dst_m = rA; end
         default:  ;
      endcase
   end

   assign valA = (src_a == R_NONE) ? '0 : regs[src_a];
   assign valB = (src_b == R_NONE) ? '0 : regs[src_b];

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_fun = 2'd0;
      case (icode)
         I_RRMOVQ:           alu_a = valA;
         I_OPQ:              begin alu_a = valA; alu_b = valB; alu_fun = ifun[1:0]; end
         I_IRMOVQ:           alu_a = valC;
         I_RMMOVQ, I_MRMOVQ: begin alu_a = valC; alu_b = valB; end
         I_CALL, I_PUSHQ:    begin alu_a = -STEP; alu_b = valB; end
         I_RET, I_POPQ:      begin alu_a = STEP;  alu_b = valB; end
         default:            ;
      endcase
   end

   // Subtraction is B - A, so overflow is judged against B's sign.
   always_comb begin
      valE    = alu_b + alu_a;
      of_next = 1'b0;
      case (alu_fun)
         2'd0: begin
            valE    = alu_b + alu_a;
            of_next = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (valE[XLEN-1] != alu_a[XLEN-1]);
         end
         2'd1: begin
            valE    = alu_b - alu_a;
            of_next = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (valE[XLEN-1] != alu_b[XLEN-1]);
         end
         2'd2:    valE = alu_a & alu_b;
         default: valE = alu_a ^ alu_b;
      endcase
   end

   always_comb begin
      cnd = 1'b0;
      if (icode == I_RRMOVQ || icode == I_JXX) begin
         case (ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (SF ^ OF) | ZF;
            4'h2:    cnd = SF ^ OF;
            4'h3:    cnd = ZF;
            4'h4:    cnd = ~ZF;
            4'h5:    cnd = ~(SF ^ OF);
            4'h6:    cnd = ~(SF ^ OF) & ~ZF;
            default: cnd = 1'b0;
         endcase
      end
   end

   assign wb_en = inst_valid & ~hlt;

   // The M write comes last so it wins when both ports target the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         ZF <= 1'b1;
         SF <= 1'b0;
         OF <= 1'b0;
      end else begin
         if (wb_en && dst_e != R_NONE) regs[dst_e] <= valE;
         if (wb_en && dst_m != R_NONE) regs[dst_m] <= valM;
         if (inst_valid && icode == I_OPQ) begin
            ZF <= (valE == '0);
            SF <= valE[XLEN-1];
            OF <= of_next;
         end
      end
   end

`ifdef REG_DEBUG_EN
   assign reg_mem0  = regs[0];
   assign reg_mem1  = regs[1];
   assign reg_mem2  = regs[2];
   assign reg_mem3  = regs[3];
   assign reg_mem4  = regs[4];
   assign reg_mem5  = regs[5];
   assign reg_mem6  = regs[6];
   assign reg_mem7  = regs[7];
   assign reg_mem8  = regs[8];
   assign reg_mem9  = regs[9];
   assign reg_mem10 = regs[10];
   assign reg_mem11 = regs[11];
   assign reg_mem12 = regs[12];
   assign reg_mem13 = regs[13];
   assign reg_mem14 = regs[14];
`endif

endmodule

// File: tb/tb_y86_fde_core.sv
// Randomized scoreboard bench for y86_fde_core: an instruction-level Y86 model predicts every
// combinational output; a negedge monitor pops and compares.
module tb_y86_fde_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] PC = '0;
   logic [79:0] imem_bytes = 80'h10;
   logic        imem_error = 1'b0;
   logic [63:0] valM = '0;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP, valA, valB, valE;
   logic        cnd, ZF, SF, OF, hlt, inst_valid;

   y86_fde_core dut (
      .clk(clk), .rst_n(rst_n), .PC(PC), .imem_bytes(imem_bytes), .imem_error(imem_error),
      .valM(valM), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
      .valA(valA), .valB(valB), .valE(valE), .cnd(cnd), .ZF(ZF), .SF(SF), .OF(OF),
      .hlt(hlt), .inst_valid(inst_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  icode, ifun, rA, rB;
      logic [63:0] valC, valP, valA, valB, valE;
      logic        cnd, ZF, SF, OF, hlt, valid;
   } exp_t;

   exp_t        expq[$];
   logic [63:0] mR [15];
   logic        mZF, mSF, mOF;
   int          checks = 0;
   int          passes = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 15; i++) mR[i] = '0;
      mZF = 1'b1;
      mSF = 1'b0;
      mOF = 1'b0;
   endfunction

   function automatic logic [63:0] rd(logic [3:0] r);
      return (r == 4'hF) ? 64'd0 : mR[r];
   endfunction

   function automatic logic condOf(logic [3:0] fn);
      case (fn)
         4'h0: return 1'b1;
         4'h1: return (mSF ^ mOF) | mZF;
         4'h2: return mSF ^ mOF;
         4'h3: return mZF;
         4'h4: return !mZF;
         4'h5: return !(mSF ^ mOF);
         4'h6: return !(mSF ^ mOF) && !mZF;
         default: return 1'b0;
      endcase
   endfunction

   // Executes one instruction on the architectural model and returns what the core should show.
   task automatic modelStep(input logic [63:0] pc, input logic [79:0] b, input logic err,
                            input logic [63:0] vm, output exp_t e);
      logic [3:0]  ic, fn, ra, rb, wer, wmr;
      logic [63:0] x, y;
      logic [64:0] wide;
      logic        legal, of;
      int          len;
      ic = b[7:4];
      fn = b[3:0];
      case (ic)
         4'h0, 4'h1, 4'h9:        len = 1;
         4'h2, 4'h6, 4'hA, 4'hB:  len = 2;
         4'h7, 4'h8:              len = 9;
         4'h3, 4'h4, 4'h5:        len = 10;
         default:                 len = 1;
      endcase
      if (ic > 4'hB)                      legal = 1'b0;
      else if (ic == 4'h2 || ic == 4'h7)  legal = (fn <= 4'h6);
      else if (ic == 4'h6)                legal = (fn <= 4'h3);
      else                                legal = (fn == 4'h0);
      ra = (legal && (len == 2 || len == 10)) ? b[15:12] : 4'hF;
      rb = (legal && (len == 2 || len == 10)) ? b[11:8]  : 4'hF;
      e.icode = ic;
      e.ifun  = fn;
      e.rA    = ra;
      e.rB    = rb;
      e.valC  = !legal ? 64'd0 : (len == 10) ? b[79:16] : (len == 9) ? b[71:8] : 64'd0;
      e.valid = legal && !err;
      e.valP  = pc + (e.valid ? 64'(len) : 64'd1);
      e.hlt   = e.valid && (ic == 4'h0);
      e.ZF = mZF; e.SF = mSF; e.OF = mOF;
      e.valA = '0; e.valB = '0; e.valE = '0; e.cnd = 1'b0;
      wer = 4'hF; wmr = 4'hF;
      case (ic)
         4'h2: begin e.valA = rd(ra); e.valE = e.valA; e.cnd = condOf(fn); if (e.cnd) wer = rb; end
         4'h3: begin e.valE = e.valC; wer = rb; end
         4'h4: begin e.valA = rd(ra); e.valB = rd(rb); e.valE = e.valB + e.valC; end
         4'h5: begin e.valB = rd(rb); e.valE = e.valB + e.valC; wmr = ra; end
         4'h6: begin
            x = rd(ra); y = rd(rb); e.valA = x; e.valB = y; of = 1'b0;
            case (fn)
               4'h0: begin wide = {y[63], y} + {x[63], x}; e.valE = wide[63:0]; of = wide[64] ^ wide[63]; end
               4'h1: begin wide = {y[63], y} - {x[63], x}; e.valE = wide[63:0]; of = wide[64] ^ wide[63]; end
               4'h2: e.valE = x & y;
               default: e.valE = x ^ y;
            endcase
            wer = rb;
            if (e.valid) begin mZF = (e.valE == 0); mSF = e.valE[63]; mOF = of; end
         end
         4'h7: e.cnd = condOf(fn);
         4'h8: begin e.valB = rd(4); e.valE = e.valB - 64'd8; wer = 4; end
         4'h9: begin e.valA = rd(4); e.valB = rd(4); e.valE = e.valB + 64'd8; wer = 4; end
         4'hA: begin e.valA = rd(ra); e.valB = rd(4); e.valE = e.valB - 64'd8; wer = 4; end
         4'hB: begin e.valA = rd(4); e.valB = rd(4); e.valE = e.valB + 64'd8; wer = 4; wmr = ra; end
         default: ;
      endcase
      if (e.valid) begin
         if (wer != 4'hF) mR[wer] = e.valE;
         if (wmr != 4'hF) mR[wmr] = vm;
      end
   endtask

   task automatic applyStimulus(input logic [63:0] pc, input logic [79:0] b, input logic err,
                                input logic [63:0] vm);
      exp_t e;
      @(posedge clk);
      #1;
      PC = pc; imem_bytes = b; imem_error = err; valM = vm;
      modelStep(pc, b, err, vm, e);
      expq.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      chk("icode", 64'(icode), 64'(e.icode));
      chk("ifun", 64'(ifun), 64'(e.ifun));
      chk("rA", 64'(rA), 64'(e.rA));
      chk("rB", 64'(rB), 64'(e.rB));
      chk("valP", valP, e.valP);
      chk("valA", valA, e.valA);
      chk("valB", valB, e.valB);
      chk("ZF", 64'(ZF), 64'(e.ZF));
      chk("SF", 64'(SF), 64'(e.SF));
      chk("OF", 64'(OF), 64'(e.OF));
      chk("hlt", 64'(hlt), 64'(e.hlt));
      chk("inst_valid", 64'(inst_valid), 64'(e.valid));
      if (e.valid) begin
         chk("valC", valC, e.valC);
         chk("valE", valE, e.valE);
         chk("cnd", 64'(cnd), 64'(e.cnd));
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput(e);
         end
      end
   end

   function automatic logic [79:0] lenTen(logic [7:0] b0, logic [7:0] b1, logic [63:0] c);
      return {c, b1, b0};
   endfunction

   function automatic logic [79:0] lenNine(logic [7:0] b0, logic [63:0] c);
      return {8'h00, c, b0};
   endfunction

   function automatic logic [79:0] lenTwo(logic [7:0] b0, logic [7:0] b1);
      return {64'h0, b1, b0};
   endfunction

   task automatic randomInstr();
      logic [79:0] b;
      logic [3:0]  ic, fn, ra, rb;
      int          r;
      b[31:0]  = $urandom();
      b[63:32] = $urandom();
      b[79:64] = 16'($urandom());
      r  = int'($urandom_range(0, 99));
      ic = 4'($urandom_range(1, 11));
      case (ic)
         4'h2, 4'h7: fn = 4'($urandom_range(0, 6));
         4'h6:       fn = 4'($urandom_range(0, 3));
         default:    fn = 4'h0;
      endcase
      if (r < 4)       ic = 4'($urandom_range(12, 15));
      else if (r < 8)  fn = 4'($urandom_range(7, 15));
      else if (r < 10) begin ic = 4'h0; fn = 4'h0; end
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if (ic == 4'h6 && (r % 3) == 0) ra = rb;
      b[7:0]  = {ic, fn};
      b[15:8] = {ra, rb};
      applyStimulus({$urandom(), $urandom()}, b, ($urandom_range(0, 19) == 0), {$urandom(), $urandom()});
   endtask

   initial begin : driver
      exp_t e;
      modelReset();
      #12 rst_n = 1'b1;
      applyStimulus(64'd0,  lenTen(8'h30, 8'hF2, 64'd10), 1'b0, 64'd0);
      applyStimulus(64'd10, lenTen(8'h30, 8'hF3, 64'd3), 1'b0, 64'd0);
      applyStimulus(64'd20, lenTwo(8'h61, 8'h23), 1'b0, 64'd0);
      applyStimulus(64'd22, lenTwo(8'h63, 8'h00), 1'b0, 64'd0);
      applyStimulus(64'd24, lenNine(8'h74, 64'h40), 1'b0, 64'd0);
      applyStimulus(64'd33, lenNine(8'h73, 64'h40), 1'b0, 64'd0);
      applyStimulus(64'd42, lenTen(8'h30, 8'hF4, 64'h100), 1'b0, 64'd0);
      applyStimulus(64'd52, lenTwo(8'hA0, 8'h3F), 1'b0, 64'd0);
      applyStimulus(64'd54, lenTwo(8'hB0, 8'h4F), 1'b0, 64'h55);
      applyStimulus(64'd56, lenTwo(8'h20, 8'h40), 1'b0, 64'd0);
      applyStimulus(64'd58, lenTwo(8'hC0, 8'h12), 1'b0, 64'd0);
      applyStimulus(64'd59, lenTwo(8'h00, 8'h00), 1'b0, 64'd0);
      applyStimulus(64'd60, lenTen(8'h30, 8'hF1, 64'h77), 1'b1, 64'd0);
      applyStimulus(64'd61, lenTwo(8'h20, 8'h14), 1'b0, 64'd0);
      for (int i = 0; i < 400; i++) randomInstr();
      applyStimulus(64'h200, lenTen(8'h30, 8'hF3, 64'd5), 1'b0, 64'd0);
      applyStimulus(64'h20A, lenTwo(8'h60, 8'h33), 1'b0, 64'd0);
      // Reset asserted between edges: the monitor samples before any clock edge arrives.
      @(posedge clk);
      #1;
      PC = 64'h300; imem_bytes = lenTwo(8'h23, 8'h34); imem_error = 1'b0; valM = '0;
      #1 rst_n = 1'b0;
      modelReset();
      modelStep(64'h300, lenTwo(8'h23, 8'h34), 1'b0, 64'd0, e);
      expq.push_back(e);
      modelReset();
      @(posedge clk);
      #1;
      imem_bytes = 80'h10;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) randomInstr();
      @(negedge clk);
      #1;
      chk("queue_drained", 64'(expq.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
